// File: rtl/synth_pkg.sv
// Shared synth definitions: frame timing, table geometry and the
// parameter-update request word.
package synth_pkg;

   localparam int SAMPLE_CYCLE_LENGTH = 2272;
   localparam int NUM_PARTIALS        = 1024;
   localparam int PARAM_WIDTH         = 18;
   localparam int INDEX_WIDTH         = $clog2(NUM_PARTIALS);

   typedef enum logic {
      SEL_INTENSITY = 1'b0,
      SEL_FREQUENCY = 1'b1
   } param_sel_t;

   typedef struct packed {
      param_sel_t             sel;
      logic [INDEX_WIDTH-1:0] index;
      logic [PARAM_WIDTH-1:0] data;
      logic                   last;
   } param_req_t;

endpackage

// File: rtl/synth_param_scheduler_if.sv
// Request handshake between a parameter producer and the scheduler.
interface synth_param_scheduler_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_sel;
   logic [9:0] req_index;
   logic [17:0] req_data;
   logic       req_last;

   modport master (output req_valid, req_sel, req_index, req_data, req_last,
                   input  req_ready);
   modport slave  (input  req_valid, req_sel, req_index, req_data, req_last,
                   output req_ready);
endinterface

// File: rtl/synth_param_scheduler_fifo.sv
// First-word-fall-through request buffer. Besides the usual flags it
// reports how many entries from the head form the first batch, so the
// scheduler can decide whether that batch fits in what is left of the
// write window.
module param_fifo
   import synth_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  param_req_t    din,
   input  logic          pop,
   output param_req_t    dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic [CW-1:0] head_len
);

   param_req_t      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            do_push, do_pop;
   logic            found;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // A push into a full buffer is fine when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array; contents are meaningless outside [rd_ptr, wr_ptr).
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Distance from head to the first stored last=1 entry, inclusive;
   // the whole occupancy when no such entry is stored.
   always_comb begin
      head_len = count;
      found    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!found && (CW'(i) < count) && mem[rd_ptr + AW'(i)].last) begin
            head_len = CW'(i + 1);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/synth_param_scheduler.sv
// Buffers parameter updates and replays them into the intensity/frequency
// tables only inside the safe part of each sample frame, one batch at a
// time, never letting a batch run past the end of the window.
module synth_param_scheduler #(
   parameter int SAMPLE_CYCLE_LENGTH = synth_pkg::SAMPLE_CYCLE_LENGTH,
   parameter int WIN_START           = 1048,
   parameter int WIN_END             = 2270,
   parameter int FIFO_DEPTH          = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [11:0]             sample_cycle_count,
   synth_param_scheduler_if.slave  req,
   output logic                    wr_en_int,
   output logic                    wr_en_freq,
   output logic [9:0]              wr_addr,
   output logic [17:0]             wr_data,
   output logic                    busy,
   output logic [4:0]              pending
);

   import synth_pkg::*;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   // The write for the final pop lands one count later, so the window
   // must end at least one count before the frame wraps.
   localparam int WIN_LAST = (WIN_END < SAMPLE_CYCLE_LENGTH - 1) ? WIN_END
                                                                : SAMPLE_CYCLE_LENGTH - 2;
   localparam logic [12:0] W_START = 13'(WIN_START);
   localparam logic [12:0] W_LAST  = 13'(WIN_LAST);

   typedef enum logic [1:0] {IDLE, WAIT_WIN, WRITE} state_t;

   state_t          state, state_n;
   param_req_t      din, dout;
   logic            push, pop, full, empty;
   logic [CW-1:0]   count, head_len, batch_len;
   logic [CW-1:0]   rem, rem_n;
   logic [CW-1:0]   complete_batches;
   logic            batch_rdy, more, in_win, fits;
   logic [12:0]     scc, room;

   assign req.req_ready = !full;
   assign push          = req.req_valid && !full;
   assign din           = '{sel:   param_sel_t'(req.req_sel),
                            index: req.req_index,
                            data:  req.req_data,
                            last:  req.req_last};

   param_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .din      (din),
      .pop      (pop),
      .dout     (dout),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .head_len (head_len)
   );

   // Number of terminated batches sitting in the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         complete_batches <= '0;
      end else begin
         case ({push && din.last, pop && dout.last})
            2'b10:   complete_batches <= complete_batches + CW'(1);
            2'b01:   complete_batches <= complete_batches - CW'(1);
            default: complete_batches <= complete_batches;
         endcase
      end
   end

   // A full buffer with no terminator is flushed as one forced batch.
   assign batch_rdy = !empty && ((complete_batches != '0) || full);
   assign batch_len = (complete_batches == '0) ? CW'(FIFO_DEPTH) : head_len;
   // Whether a batch remains once the entry now at the head has left.
   assign more      = dout.last ? (complete_batches > CW'(1)) : (complete_batches != '0);

   assign scc    = {1'b0, sample_cycle_count};
   assign in_win = (scc >= W_START) && (scc <= W_LAST);
   assign room   = W_LAST - scc + 13'd1;
   assign fits   = in_win && (room >= 13'(batch_len));

   // State and remaining-entry counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rem   <= '0;
      end else begin
         state <= state_n;
         rem   <= rem_n;
      end
   end

   // Next state and pop. The first entry pops in the same cycle the fit
   // check passes, so the first write appears one count after window entry.
   always_comb begin
      state_n = state;
      rem_n   = rem;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (batch_rdy) state_n = WAIT_WIN;
         end
         WAIT_WIN: begin
            if (!batch_rdy) begin
               state_n = IDLE;
            end else if (fits) begin
               pop = 1'b1;
               if (batch_len == CW'(1)) begin
                  state_n = more ? WAIT_WIN : IDLE;
               end else begin
                  state_n = WRITE;
                  rem_n   = batch_len - CW'(1);
               end
            end
         end
         WRITE: begin
            pop   = !empty;
            rem_n = rem - CW'(1);
            if (rem == CW'(1)) state_n = more ? WAIT_WIN : IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Registered table write port, one cycle behind the pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_int  <= 1'b0;
         wr_en_freq <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         wr_en_int  <= pop && (dout.sel == SEL_INTENSITY);
         wr_en_freq <= pop && (dout.sel == SEL_FREQUENCY);
         if (pop) begin
            wr_addr <= dout.index;
            wr_data <= dout.data;
         end
      end
   end

   assign busy    = (state == WRITE);
   assign pending = 5'(count);

endmodule
